// File: rtl/operand_loader.sv
// Loads an operand pair {A,B} from a shared switch bus, one button press per operand.
// The raw button is synchronized and edge-detected so each press advances the FSM once.
module operand_loader #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   value,
    input  logic           load_btn,
    input  logic           clear,
    output logic [2*N-1:0] ab,
    output logic           ab_valid,
    output logic [1:0]     state_o,
    output logic [7:0]     pair_count
);

    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        DONE   = 2'b10
    } state_t;

    state_t       state_q;
    logic         sync1_q, sync2_q, hist_q;
    logic         load_pulse;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic [N-1:0] ab_a_q;
    logic         ab_valid_q;
    logic [7:0]   cnt_q;

    // Synchronizer and history flops are untouched by clear, so a button held
    // through clear cannot produce a fresh edge afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= load_btn;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign load_pulse = sync2_q & ~hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WAIT_A;
            a_q        <= '0;
            b_q        <= '0;
            ab_a_q     <= '0;
            ab_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            ab_valid_q <= 1'b0;
            if (clear) begin
                state_q <= WAIT_A;
                a_q     <= '0;
                b_q     <= '0;
                ab_a_q  <= '0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    WAIT_A: begin
                        if (load_pulse) begin
                            a_q     <= value;
                            state_q <= WAIT_B;
                        end
                    end
                    WAIT_B: begin
                        if (load_pulse) begin
                            b_q        <= value;
                            ab_a_q     <= a_q;
                            ab_valid_q <= 1'b1;
                            cnt_q      <= cnt_q + 8'd1;
                            state_q    <= DONE;
                        end
                    end
                    DONE: begin
                        if (load_pulse) begin
                            a_q     <= value;
                            state_q <= WAIT_B;
                        end
                    end
                    default: state_q <= WAIT_A;
                endcase
            end
        end
    end

    // B only changes when a pair completes, so it doubles as the low half of ab.
    assign ab         = {ab_a_q, b_q};
    assign ab_valid   = ab_valid_q;
    assign state_o    = state_q;
    assign pair_count = cnt_q;

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: expected pairs are queued at stimulus time
// and matched against pairs recorded on every ab_valid cycle.
module tb_operand_loader;

    localparam int N = 8;

    logic           clk;
    logic           rst;
    logic [N-1:0]   value;
    logic           load_btn;
    logic           clear;
    logic [2*N-1:0] ab;
    logic           ab_valid;
    logic [1:0]     state_o;
    logic [7:0]     pair_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [23:0] exp_q[$];
    logic [23:0] obs_mem [0:1023];
    int          obs_wr = 0;
    int          obs_rd = 0;

    operand_loader #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .load_btn   (load_btn),
        .clear      (clear),
        .ab         (ab),
        .ab_valid   (ab_valid),
        .state_o    (state_o),
        .pair_count (pair_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every ab_valid cycle is recorded; a pulse longer than one cycle shows up as an extra entry.
    always @(negedge clk) begin
        if (ab_valid === 1'b1 && obs_wr < 1024) begin
            obs_mem[obs_wr] <= {pair_count, ab};
            obs_wr          <= obs_wr + 1;
        end
    end

    task automatic press(input logic [7:0] v);
        @(negedge clk);
        value    = v;
        load_btn = 1'b1;
        repeat (3) @(negedge clk);
        load_btn = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; load_btn = 1'b0; value = '0;
        #23;
        n_cmp++;
        if ({state_o, ab, ab_valid, pair_count} !== 27'd0) begin
            n_bad++;
            $display("FAIL reset: state=%b ab=%h valid=%b cnt=%0d, want all 0", state_o, ab, ab_valid, pair_count);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_latency_hold();
        logic [23:0] e, o;
        @(negedge clk);
        value = 8'h3C; load_btn = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (state_o !== 2'b00) begin n_bad++; $display("FAIL lat_k: state=%b want 00", state_o); end
        @(posedge clk); #1;
        n_cmp++;
        if (state_o !== 2'b00) begin n_bad++; $display("FAIL lat_k1: state=%b want 00", state_o); end
        @(posedge clk); #1;
        n_cmp++;
        if (state_o !== 2'b01) begin n_bad++; $display("FAIL lat_k2: state=%b want 01", state_o); end
        value = 8'h77;
        repeat (47) @(negedge clk);
        load_btn = 1'b0;
        n_cmp++;
        if (state_o !== 2'b01) begin n_bad++; $display("FAIL hold: state=%b want 01", state_o); end
        repeat (4) @(negedge clk);
        // Basic pair completes with A captured at k+2, not the later 8'h77.
        exp_q.push_back({8'd1, 16'h3CA5});
        press(8'hA5);
        n_cmp++;
        if (state_o !== 2'b10 || pair_count !== 8'd1) begin
            n_bad++; $display("FAIL basic_state: state=%b cnt=%0d want 10/1", state_o, pair_count);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_rd >= obs_wr) begin n_bad++; $display("FAIL basic_pair: no pair recorded, want %h", e); end
            else begin
                o = obs_mem[obs_rd]; obs_rd++;
                if (o !== e) begin n_bad++; $display("FAIL basic_pair: got %h want %h", o, e); end
            end
        end
        n_cmp++;
        if (obs_rd != obs_wr) begin n_bad++; $display("FAIL basic_extra: %0d extra valid cycles, want 0", obs_wr - obs_rd); obs_rd = obs_wr; end
    endtask

    task automatic test_reload();
        logic [23:0] e, o;
        press(8'h11);
        n_cmp++;
        if (state_o !== 2'b01 || ab !== 16'h3CA5 || pair_count !== 8'd1) begin
            n_bad++; $display("FAIL reload_hold: state=%b ab=%h cnt=%0d want 01/3ca5/1", state_o, ab, pair_count);
        end
        exp_q.push_back({8'd2, 16'h1122});
        press(8'h22);
        n_cmp++;
        if (state_o !== 2'b10 || pair_count !== 8'd2) begin
            n_bad++; $display("FAIL reload_state: state=%b cnt=%0d want 10/2", state_o, pair_count);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_rd >= obs_wr) begin n_bad++; $display("FAIL reload_pair: no pair recorded, want %h", e); end
            else begin
                o = obs_mem[obs_rd]; obs_rd++;
                if (o !== e) begin n_bad++; $display("FAIL reload_pair: got %h want %h", o, e); end
            end
        end
        n_cmp++;
        if (obs_rd != obs_wr) begin n_bad++; $display("FAIL reload_extra: %0d extra valid cycles, want 0", obs_wr - obs_rd); obs_rd = obs_wr; end
    endtask

    task automatic test_clear_collision();
        logic [23:0] e, o;
        press(8'h55);
        n_cmp++;
        if (state_o !== 2'b01) begin n_bad++; $display("FAIL clr_pre: state=%b want 01", state_o); end
        @(negedge clk);
        value = 8'h66; load_btn = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_cmp++;
        if ({state_o, ab, ab_valid, pair_count} !== 27'd0) begin
            n_bad++;
            $display("FAIL clr_collide: state=%b ab=%h valid=%b cnt=%0d want all 0", state_o, ab, ab_valid, pair_count);
        end
        repeat (6) @(negedge clk);
        n_cmp++;
        if (state_o !== 2'b00) begin n_bad++; $display("FAIL clr_retrigger: state=%b want 00", state_o); end
        load_btn = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (obs_rd != obs_wr) begin n_bad++; $display("FAIL clr_valid: %0d valid cycles, want 0", obs_wr - obs_rd); obs_rd = obs_wr; end
        press(8'h01);
        exp_q.push_back({8'd1, 16'h0102});
        press(8'h02);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_rd >= obs_wr) begin n_bad++; $display("FAIL clr_pair: no pair recorded, want %h", e); end
            else begin
                o = obs_mem[obs_rd]; obs_rd++;
                if (o !== e) begin n_bad++; $display("FAIL clr_pair: got %h want %h", o, e); end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [23:0] e, o;
        press(8'h99);
        n_cmp++;
        if (state_o !== 2'b01) begin n_bad++; $display("FAIL arst_pre: state=%b want 01", state_o); end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({state_o, ab, ab_valid, pair_count} !== 27'd0) begin
            n_bad++;
            $display("FAIL arst_async: state=%b ab=%h valid=%b cnt=%0d want all 0", state_o, ab, ab_valid, pair_count);
        end
        #1 rst = 1'b0;
        press(8'h33);
        n_cmp++;
        if (state_o !== 2'b01) begin n_bad++; $display("FAIL arst_first: state=%b want 01", state_o); end
        exp_q.push_back({8'd1, 16'h3344});
        press(8'h44);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_rd >= obs_wr) begin n_bad++; $display("FAIL arst_pair: no pair recorded, want %h", e); end
            else begin
                o = obs_mem[obs_rd]; obs_rd++;
                if (o !== e) begin n_bad++; $display("FAIL arst_pair: got %h want %h", o, e); end
            end
        end
    endtask

    task automatic test_held_reset();
        logic [23:0] e, o;
        @(negedge clk);
        value = 8'h5A; load_btn = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (state_o !== 2'b00) begin n_bad++; $display("FAIL held_e1: state=%b want 00", state_o); end
        @(posedge clk); #1;
        n_cmp++;
        if (state_o !== 2'b00) begin n_bad++; $display("FAIL held_e2: state=%b want 00", state_o); end
        @(posedge clk); #1;
        n_cmp++;
        if (state_o !== 2'b01) begin n_bad++; $display("FAIL held_e3: state=%b want 01", state_o); end
        repeat (10) @(negedge clk);
        load_btn = 1'b0;
        repeat (4) @(negedge clk);
        exp_q.push_back({8'd1, 16'h5AC3});
        press(8'hC3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_rd >= obs_wr) begin n_bad++; $display("FAIL held_pair: no pair recorded, want %h", e); end
            else begin
                o = obs_mem[obs_rd]; obs_rd++;
                if (o !== e) begin n_bad++; $display("FAIL held_pair: got %h want %h", o, e); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [23:0] e, o;
        logic [7:0]  a8, c8;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_cmp++;
        if (pair_count !== 8'd0) begin n_bad++; $display("FAIL wrap_start: cnt=%0d want 0", pair_count); end
        for (int i = 0; i < 256; i++) begin
            a8 = i[7:0];
            c8 = a8 + 8'd1;
            exp_q.push_back({c8, a8, ~a8});
            press(a8);
            press(~a8);
        end
        n_cmp++;
        if (pair_count !== 8'd0 || state_o !== 2'b10) begin
            n_bad++; $display("FAIL wrap_end: cnt=%0d state=%b want 0/10", pair_count, state_o);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_rd >= obs_wr) begin n_bad++; $display("FAIL wrap_pair: no pair recorded, want %h", e); end
            else begin
                o = obs_mem[obs_rd]; obs_rd++;
                if (o !== e) begin n_bad++; $display("FAIL wrap_pair: got %h want %h", o, e); end
            end
        end
        n_cmp++;
        if (obs_rd != obs_wr) begin n_bad++; $display("FAIL wrap_extra: %0d extra valid cycles, want 0", obs_wr - obs_rd); end
    endtask

    initial begin
        test_reset();
        test_latency_hold();
        test_reload();
        test_clear_collision();
        test_async_reset();
        test_held_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
